// File: rtl/sram_sync_clr.sv
// -----------------------------------------------------------------------------
// sram_sync_clr
// Single-port synchronous static RAM with per-bit write mask, one stored
// even-parity bit per word and a built-in clear sequencer. After reset or a
// clr_req pulse, the sequencer writes INIT_VAL to every word, one word per
// cycle, so the memory never holds undefined contents.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; restarts the clear sequence
//   ce        access request, honoured only when not busy
//   we        1 = write, 0 = read (qualified by ce)
//   addr      word address (AW bits)
//   din       write data (DW bits)
//   wmask     per-bit write enable; 1 = take that bit from din
//   clr_req   pulse: re-run the clear sequence (wins over a same-cycle access)
//   perr_inj  during a write, store inverted parity
//   dout      registered read data; holds between reads
//   rvalid    one-cycle strobe: dout/perr carry a new read result
//   perr      parity mismatch on the word now in dout
//   busy      clear sequence in progress; accesses are ignored
// -----------------------------------------------------------------------------
module sram_sync_clr #(
   parameter int            AW       = 10,
   parameter int            DW       = 1,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   input  logic [DW-1:0] wmask,
   input  logic          clr_req,
   input  logic          perr_inj,
   output logic [DW-1:0] dout,
   output logic          rvalid,
   output logic          perr,
   output logic          busy
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   function automatic logic f_parity(input logic [DW-1:0] d);
      return ^d;
   endfunction

   // Each word is {parity, data}.
   logic [DW:0]   r_mem [DEPTH];
   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic [DW-1:0] r_dout;
   logic          r_rvalid;
   logic          r_perr;

   logic [DW:0]   w_old;
   logic [DW-1:0] w_merged;
   logic          w_acc;
   logic          w_wr;
   logic          w_clr_wr;

   // An access is taken only in READY, and a same-cycle clr_req drops it.
   assign w_acc    = (r_state == S_READY) && !reset && !clr_req && ce;
   assign w_wr     = w_acc && we;
   assign w_clr_wr = (r_state == S_CLEAR) && !reset;
   assign w_old    = r_mem[addr];
   assign w_merged = (w_old[DW-1:0] & ~wmask) | (din & wmask);

   // Storage: clear writes take the counter address, normal writes merge
   // under the mask and always rewrite parity, even with wmask = 0.
   always_ff @(posedge clk) begin
      if (w_clr_wr) begin
         r_mem[r_cnt] <= {f_parity(INIT_VAL), INIT_VAL};
      end else if (w_wr) begin
         r_mem[addr] <= {f_parity(w_merged) ^ perr_inj, w_merged};
      end
   end

   // Sequencer and read path.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_CLEAR;
         r_cnt    <= '0;
         r_dout   <= '0;
         r_rvalid <= 1'b0;
         r_perr   <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_rvalid <= 1'b0;
               // Counter wraps to 0 on the last word, ready for the next clear.
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == {AW{1'b1}}) begin
                  r_state <= S_READY;
               end
            end
            default: begin
               if (clr_req) begin
                  r_state  <= S_CLEAR;
                  r_cnt    <= '0;
                  r_rvalid <= 1'b0;
               end else if (ce && !we) begin
                  r_dout   <= w_old[DW-1:0];
                  r_perr   <= f_parity(w_old[DW-1:0]) != w_old[DW];
                  r_rvalid <= 1'b1;
               end else begin
                  r_rvalid <= 1'b0;
               end
            end
         endcase
      end
   end

   assign dout   = r_dout;
   assign rvalid = r_rvalid;
   assign perr   = r_perr;
   assign busy   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_sram_sync_clr.sv
// -----------------------------------------------------------------------------
// tb_sram_sync_clr
// Directed bench for sram_sync_clr. Read requests push the expected word,
// parity flag and issue cycle into a queue; a separate monitor pops on each
// rvalid and checks data, parity and 1-cycle latency, and checks that dout
// and perr hold when rvalid is low. A second instance with default
// parameters checks the 1024-cycle clear length.
// -----------------------------------------------------------------------------
module tb_sram_sync_clr;

   typedef struct {
      int       c;
      logic [7:0] d;
      logic     p;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ce = 1'b0, we = 1'b0, clr_req = 1'b0, perr_inj = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] din = '0, wmask = '0;
   logic [7:0] dout;
   logic       rvalid, perr, busy;

   // Default-parameter instance (AW=10, DW=1), inputs idle.
   logic       d_ce = 1'b0, d_we = 1'b0, d_clr = 1'b0, d_inj = 1'b0;
   logic [9:0] d_addr = '0;
   logic [0:0] d_din = '0, d_wmask = '0;
   logic [0:0] d_dout;
   logic       d_rvalid, d_perr, d_busy;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   logic rst_s = 1'b0;
   exp_t q[$];

   sram_sync_clr #(.AW(4), .DW(8), .INIT_VAL(8'hA5)) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .we(we), .addr(addr), .din(din),
      .wmask(wmask), .clr_req(clr_req), .perr_inj(perr_inj),
      .dout(dout), .rvalid(rvalid), .perr(perr), .busy(busy)
   );

   sram_sync_clr u_def (
      .clk(clk), .reset(reset), .ce(d_ce), .we(d_we), .addr(d_addr), .din(d_din),
      .wmask(d_wmask), .clr_req(d_clr), .perr_inj(d_inj),
      .dout(d_dout), .rvalid(d_rvalid), .perr(d_perr), .busy(d_busy)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc   = cyc + 1;
         rst_s = reset;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: decoupled from stimulus.
   initial begin
      logic [7:0] last_d;
      logic       last_p;
      logic       armed;
      exp_t       e;
      armed  = 1'b0;
      last_d = '0;
      last_p = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_s) begin
            armed = 1'b1;
            check("reset_dout", 32'(dout), 32'h0);
            check("reset_rvalid", 32'(rvalid), 32'h0);
            check("reset_perr", 32'(perr), 32'h0);
            last_d = '0;
            last_p = 1'b0;
         end else if (armed) begin
            if (rvalid === 1'b1) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_rvalid: got rvalid=1 dout=%0h, expected no read (cycle %0d)", dout, cyc);
               end else begin
                  e = q.pop_front();
                  check("read_dout", 32'(dout), 32'(e.d));
                  check("read_perr", 32'(perr), 32'(e.p));
                  check("read_latency", 32'(cyc), 32'(e.c + 1));
                  last_d = dout;
                  last_p = perr;
               end
            end else begin
               check("rvalid_known", 32'(rvalid), 32'h0);
               check("hold_dout", 32'(dout), 32'(last_d));
               check("hold_perr", 32'(perr), 32'(last_p));
            end
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      ce = 0; we = 0; clr_req = 0; perr_inj = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m, input logic inj);
      @(negedge clk);
      ce = 1; we = 1; addr = a; din = d; wmask = m; perr_inj = inj; clr_req = 0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] ed, input logic ep);
      exp_t e;
      @(negedge clk);
      ce = 1; we = 0; addr = a; perr_inj = 0; clr_req = 0;
      e.c = cyc; e.d = ed; e.p = ep;
      q.push_back(e);
   endtask

   // Called at the first negedge after the edge that started a clear. Drives
   // ignored writes and clr_req pulses while busy; stops after 'limit' cycles.
   task automatic count_busy(input int limit, output int n);
      n = 0;
      while (busy === 1'b1 && n < limit) begin
         n++;
         ce = 1; we = n[0]; addr = 4'd0; din = 8'h00; wmask = 8'hFF; clr_req = n[1];
         @(negedge clk);
      end
      ce = 0; we = 0; clr_req = 0;
   endtask

   initial begin
      int n0, n1, n;

      // 1: reset, clear length on both instances, then read all words.
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("busy_after_reset", 32'(busy), 32'h1);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 1100 && (busy === 1'b1 || d_busy === 1'b1); i++) begin
         if (busy === 1'b1) n0++;
         if (d_busy === 1'b1) n1++;
         @(negedge clk);
      end
      check("clear_len_16", 32'(n0), 32'd16);
      check("clear_len_1024", 32'(n1), 32'd1024);
      check("def_rvalid", 32'(d_rvalid), 32'h0);
      for (int i = 0; i < 16; i++) rd(4'(i), 8'hA5, 1'b0);
      idle();

      // 2: write then read same address next cycle, then a read burst.
      wr(4'd3, 8'h3C, 8'hFF, 1'b0);
      rd(4'd3, 8'h3C, 1'b0);
      rd(4'd0, 8'hA5, 1'b0);
      rd(4'd3, 8'h3C, 1'b0);
      rd(4'd0, 8'hA5, 1'b0);
      rd(4'd3, 8'h3C, 1'b0);
      idle();

      // 3: masked write merges low nibble.
      wr(4'd3, 8'hFF, 8'h0F, 1'b0);
      idle();
      rd(4'd3, 8'h3F, 1'b0);
      idle();

      // 4: parity injection and repair; wmask=0 corrupts parity only.
      wr(4'd5, 8'h01, 8'hFF, 1'b1);
      rd(4'd5, 8'h01, 1'b1);
      idle();
      idle();
      wr(4'd5, 8'h01, 8'hFF, 1'b0);
      rd(4'd5, 8'h01, 1'b0);
      wr(4'd6, 8'hFF, 8'h00, 1'b1);
      rd(4'd6, 8'hA5, 1'b1);
      idle();

      // 5: clr_req beats a simultaneous write.
      @(negedge clk);
      ce = 1; we = 1; addr = 4'd7; din = 8'h00; wmask = 8'hFF; clr_req = 1;
      @(negedge clk);
      count_busy(100, n);
      check("clr_req_len", 32'(n), 32'd16);
      rd(4'd7, 8'hA5, 1'b0);
      rd(4'd3, 8'hA5, 1'b0);
      rd(4'd5, 8'hA5, 1'b0);
      rd(4'd6, 8'hA5, 1'b0);
      idle();

      // 6: reset at clear cycle 9 restarts a full clear.
      @(negedge clk);
      clr_req = 1;
      @(negedge clk);
      count_busy(9, n);
      check("partial_clear", 32'(n), 32'd9);
      reset = 1;
      @(negedge clk);
      reset = 0;
      count_busy(100, n);
      check("restart_len", 32'(n), 32'd16);
      rd(4'd0, 8'hA5, 1'b0);
      rd(4'd1, 8'hA5, 1'b0);
      rd(4'd15, 8'hA5, 1'b0);
      idle();
      idle();
      idle();
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_sync_clr.md
Name: sram_sync_clr

Overview:
- Parametrised, single-port synchronous static RAM for the CADR memory models. It is the generalised successor to the 1-bit-wide static RAM parts.
- Configurable address and data width.
- Registered read data with a valid strobe.
- Per-bit write mask.
- Stored even-parity bit per word with error flagging.
- Built-in clear sequencer that initialises every word after reset or on request, so simulations never start on X contents.

Parameters:
AW, 10, address width in bits; DEPTH = 2**AW words
DW, 1, data width in bits
INIT_VAL, 0, DW-bit value written to every word by the clear sequencer

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
ce  input  1  access request; sampled only in READY
we  input  1  1 = write, 0 = read; qualified by ce
addr  input  AW  word address
din  input  DW  write data
wmask  input  DW  per-bit write enable; 1 = update that bit
clr_req  input  1  pulse: re-run the clear sequence
perr_inj  input  1  when 1 during a write, stores inverted parity (test hook)
dout  output  DW  registered read data
rvalid  output  1  one-cycle strobe: dout holds new read data
perr  output  1  parity mismatch on the word in dout; valid with rvalid
busy  output  1  clear sequence in progress; accesses ignored

Behaviour:
- Storage: DEPTH words of DW data bits plus 1 parity bit. Parity = XOR of the stored data bits (even parity).
- Reset (sync, clk edge with reset=1):
  - dout=0, rvalid=0, perr=0.
  - FSM enters CLEAR with clear counter = 0; busy=1 from the next cycle.
  - Memory contents are not touched in the reset cycle itself.
  - Reset asserted mid-clear or mid-access restarts CLEAR from address 0.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes INIT_VAL and its correct parity to word[counter], then increments counter.
  - After writing word DEPTH-1, moves to READY. The counter wraps to 0; there is no extra cycle.
  - busy=1 throughout CLEAR, for exactly DEPTH cycles, then 0.
  - ce, we and clr_req are ignored; rvalid stays 0.
- READY, clr_req=1: enters CLEAR with counter=0. clr_req takes priority over a simultaneous ce; that access is dropped.
- READY, ce=1, we=1 (write):
  - new = (old & ~wmask) | (din & wmask).
  - Stored parity = XOR(new) ^ perr_inj, recomputed over the full merged word.
  - rvalid=0 next cycle; dout and perr hold their previous values.
- READY, ce=1, we=0 (read):
  - At the next edge, dout = word[addr], rvalid=1, perr = XOR(word) != stored parity.
  - Latency is exactly 1 cycle. Back-to-back reads give one result per cycle.
- READY, ce=0: rvalid=0 next cycle; dout and perr hold.
- Read after write to the same address on the next cycle returns the merged word; there is no bypass hazard.
- Single port: no simultaneous read and write.
- wmask=0 write: the word is unchanged, but parity is rewritten. This lets perr_inj corrupt parity without changing data.
- addr is always in range (width-exact). Out-of-range addresses do not exist.
- X/Z is never driven on dout. The old tri-state output model is replaced by dout plus rvalid.

Test Plan:
1. AW=4, DW=8, INIT_VAL=8'hA5: reset one cycle -> busy=1 for exactly 16 cycles, then 0. Reads of addr 0..15 each return 8'hA5, rvalid=1 one cycle after ce, perr=0.
2. AW=4, DW=8: write addr 3 din=8'h3C wmask=8'hFF, then read addr 3 next cycle -> dout=8'h3C, rvalid=1, perr=0. A 4-cycle read burst of addrs 0,3,0,3 returns A5,3C,A5,3C on consecutive cycles.
3. Masked write: addr 3 holds 8'h3C; write din=8'hFF wmask=8'h0F -> read returns 8'h3F, perr=0.
4. Parity injection: write addr 5 din=8'h01 wmask=8'hFF perr_inj=1 -> read addr 5 gives dout=8'h01, perr=1. A rewrite with perr_inj=0 -> perr=0.
5. clr_req with ce=1 we=1 addr 7 din=8'h00 in the same cycle -> write dropped, busy=1 for 16 cycles. Afterwards addr 7 reads 8'hA5 and all prior writes are erased.
6. Reset asserted at clear cycle 9 -> busy stays 1 for another full 16 cycles. ce pulses during busy produce no rvalid and do not change memory. Default AW=10, DW=1: busy lasts 1024 cycles.
